// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant stays locked until end of packet, MAX_BURST bytes, or LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  MAX_BURST    = 16,
  parameter int  LOCK_TIMEOUT = 64,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 send_request,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [15:0]          bytes_sent
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                grant_valid_q, grant_valid_d;
  logic [7:0]          burst_q, burst_d;
  logic [15:0]         timeout_q, timeout_d;
  logic                last_q, last_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                send_request_q, send_request_d;
  logic [15:0]         bytes_sent_q, bytes_sent_d;

  logic [ID_W:0]       pick;
  logic [ID_W-1:0]     next_ptr;
  logic                sel_valid;
  logic                sel_last;
  logic [7:0]          sel_data;
  logic                timeout_hit;
  logic                burst_full;
  logic                release_grant;

  // MSB flags a hit; lowest offset from the pointer wins since it is written last.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (vld[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  assign pick        = rr_pick(req_valid, ptr_q);
  assign sel_valid   = req_valid[grant_id_q];
  assign sel_last    = req_last[grant_id_q];
  assign sel_data    = req_data[{grant_id_q, 3'b000} +: 8];
  assign timeout_hit = ({1'b0, timeout_q} + 17'd1) == 17'(LOCK_TIMEOUT);
  assign burst_full  = (burst_q == 8'(MAX_BURST));
  assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign release_grant = ((state_q == LOAD) && !sel_valid && timeout_hit) ||
                         ((state_q == WAIT_DONE) && tx_done && (last_q || burst_full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick[ID_W]) state_d = LOAD;
      LOAD:      if (sel_valid) state_d = SEND;
                 else if (release_grant) state_d = IDLE;
      SEND:      if (!tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_d = release_grant ? IDLE : LOAD;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    grant_valid_d  = grant_valid_q;
    burst_d        = burst_q;
    timeout_d      = timeout_q;
    last_d         = last_q;
    tx_data_d      = tx_data_q;
    req_ready_d    = '0;
    send_request_d = 1'b0;
    bytes_sent_d   = bytes_sent_q;
    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          grant_id_d    = pick[ID_W-1:0];
          grant_valid_d = 1'b1;
          burst_d       = '0;
          timeout_d     = '0;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          req_ready_d = NUM_REQ'(1) << grant_id_q;
          tx_data_d   = sel_data;
          last_d      = sel_last;
          burst_d     = burst_q + 8'd1;
          timeout_d   = '0;
        end else begin
          timeout_d = timeout_q + 16'd1;
        end
      end
      SEND:      send_request_d = !tx_busy;
      WAIT_DONE: if (tx_done) bytes_sent_d = bytes_sent_q + 16'd1;
      default: ;
    endcase
    // Release overrides the per-state updates; grant_id deliberately keeps its value.
    if (release_grant) begin
      grant_valid_d = 1'b0;
      ptr_d         = next_ptr;
      timeout_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q          <= '0;
      grant_id_q     <= '0;
      grant_valid_q  <= 1'b0;
      burst_q        <= '0;
      timeout_q      <= '0;
      last_q         <= 1'b0;
      tx_data_q      <= '0;
      req_ready_q    <= '0;
      send_request_q <= 1'b0;
      bytes_sent_q   <= '0;
    end else begin
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      grant_valid_q  <= grant_valid_d;
      burst_q        <= burst_d;
      timeout_q      <= timeout_d;
      last_q         <= last_d;
      tx_data_q      <= tx_data_d;
      req_ready_q    <= req_ready_d;
      send_request_q <= send_request_d;
      bytes_sent_q   <= bytes_sent_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign send_request = send_request_q;
  assign tx_data      = tx_data_q;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign bytes_sent   = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference of the grant/packet-lock rules.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int TMO  = 8;
  localparam int ULEN = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           send_request;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [15:0]    bytes_sent;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .send_request(send_request),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_valid(grant_valid), .grant_id(grant_id), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester byte queues {last, data}, UART model and phase bookkeeping
  logic [8:0] rq [N][$];
  logic [7:0] gen_q [N][$];
  logic [7:0] got_q [N][$];
  logic [7:0] log_q [$];
  int gap [N];
  int u_cnt, cyc, c0;
  bit gap_en, noise, u_rand, busy_force;
  int first_ready, first_send, n_send, n_ready, n_g2;

  // reference: owner (-1 = none), rotation pointer, burst/quiet counts, byte phase
  int         m_own, m_ptr, m_gid, m_burst, m_quiet, m_phase;
  logic [7:0] m_txd;
  logic       m_last;
  logic [15:0] m_bytes;
  logic [N-1:0] exp_ready;
  logic       exp_send;

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_gid = 0; m_burst = 0; m_quiet = 0; m_phase = 0;
    m_txd = 8'h00; m_last = 1'b0; m_bytes = 16'h0000;
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int c);
    return v[c[1:0]];
  endfunction

  task automatic model_release();
    m_own = -1;
    m_ptr = (m_gid + 1) % N;
  endtask

  task automatic model_update();
    exp_ready = '0;
    exp_send  = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_own < 0 && vbit(req_valid, (m_ptr + k) % N)) m_own = (m_ptr + k) % N;
      end
      if (m_own >= 0) begin
        m_gid = m_own; m_burst = 0; m_quiet = 0; m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (vbit(req_valid, m_own)) begin
        exp_ready = 4'b0001 << m_own;
        m_txd     = 8'(req_data >> (8 * m_own));
        m_last    = vbit(req_last, m_own);
        m_burst++;
        m_quiet   = 0;
        m_phase   = 1;
      end else begin
        m_quiet++;
        if (m_quiet == TMO) model_release();
      end
    end else if (m_phase == 1) begin
      if (!tx_busy) begin
        exp_send = 1'b1;
        m_phase  = 2;
      end
    end else if (tx_done) begin
      m_bytes = m_bytes + 16'd1;
      m_phase = 0;
      if (m_last || m_burst == MAXB) model_release();
    end
  endtask

  task automatic observe();
    chk("grant_valid", grant_valid, (m_own >= 0));
    chk("grant_id", grant_id, m_gid);
    chk("req_ready", req_ready, exp_ready);
    chk("send_request", send_request, exp_send);
    chk("tx_data", tx_data, m_txd);
    chk("bytes_sent", bytes_sent, m_bytes);
    if (req_ready != 0) begin
      n_ready++;
      if (first_ready < 0) first_ready = cyc;
    end
    if (send_request) begin
      n_send++;
      if (first_send < 0) first_send = cyc;
      log_q.push_back(tx_data);
      got_q[grant_id].push_back(tx_data);
    end
    if (grant_valid && grant_id == 2'd2) n_g2++;
  endtask

  task automatic drive();
    tx_done = 1'b0;
    if (!reset) begin
      tx_busy = 1'b0;
      u_cnt   = 0;
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end else if (send_request) begin
      tx_busy = 1'b1;
      u_cnt   = u_rand ? int'($urandom_range(2, 6)) : ULEN;
    end else begin
      tx_busy = busy_force || (noise && $urandom_range(0, 3) == 0);
      tx_done = noise && ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        req_valid[i] = 1'b0;
        gap[i] = (gap_en && $urandom_range(0, 9) < 3) ? int'($urandom_range(1, 12)) : 0;
      end
      if (!req_valid[i]) begin
        if (gap[i] > 0) gap[i]--;
        else if (rq[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = rq[i][0][7:0];
          req_last[i]         = rq[i][0][8];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    model_update();
    observe();
    drive();
    cyc++;
  endtask

  function automatic bit idle_now();
    bit empty;
    empty = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) empty = 1'b0;
    return empty && (m_own < 0) && (u_cnt == 0) && (req_valid == '0);
  endfunction

  task automatic drain(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      step();
      ok = idle_now();
    end
    chk(tag, ok, 1);
  endtask

  task automatic begin_phase();
    log_q.delete();
    first_ready = -1; first_send = -1;
    n_send = 0; n_ready = 0; n_g2 = 0;
    c0 = cyc;
  endtask

  function automatic logic [31:0] log_at(input int k);
    return (log_q.size() > k) ? 32'(log_q[k]) : 32'hDEAD;
  endfunction

  task automatic chk_zero(input string p);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_send"}, send_request, 0);
    chk({p, "_txdata"}, tx_data, 0);
    chk({p, "_gvalid"}, grant_valid, 0);
    chk({p, "_gid"}, grant_id, 0);
    chk({p, "_bytes"}, bytes_sent, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [7:0] exp_e [5]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
  logic [7:0] exp_f [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_g [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hC3, 8'h04,
                             8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    gap_en = 0; noise = 0; u_rand = 0; busy_force = 0; u_cnt = 0; cyc = 0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    model_reset();
    begin_phase();
    #1;
    chk_zero("rst");
    step();
    step();
    reset = 1'b1;

    // single byte from requester 2
    begin_phase();
    rq[2].push_back({1'b1, 8'h5A});
    drain("b_drain", 200);
    chk("b_ready_lat", first_ready - c0, 2);
    chk("b_send_lat", first_send - c0, 3);
    chk("b_data", log_at(0), 8'h5A);
    chk("b_bytes", bytes_sent, 1);
    chk("b_gvalid", grant_valid, 0);

    // pointer now sits at 3, so requester 3 beats requester 0
    begin_phase();
    rq[0].push_back({1'b1, 8'hA0});
    rq[3].push_back({1'b1, 8'hA3});
    drain("c_drain", 200);
    chk("c_first", log_at(0), 8'hA3);
    chk("c_second", log_at(1), 8'hA0);

    // tx_busy holds the send; then reset lands in the middle of the transfer
    begin_phase();
    busy_force = 1;
    rq[1].push_back({1'b1, 8'h77});
    repeat (12) step();
    chk("i_hold_send", n_send, 0);
    chk("i_hold_ready", n_ready, 1);
    busy_force = 0;
    for (int k = 0; k < 20 && n_send == 0; k++) step();
    chk("i_send_after", n_send, 1);
    chk("i_send_data", log_at(0), 8'h77);
    #2 reset = 1'b0;
    #1 chk_zero("mid_rst");
    tx_busy = 1'b0; tx_done = 1'b0; u_cnt = 0;
    model_reset();
    step();
    step();
    reset = 1'b1;

    // round robin from reset
    begin_phase();
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hB0});
    rq[1].push_back({1'b1, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    rq[3].push_back({1'b1, 8'hA3});
    drain("e_drain", 400);
    for (int k = 0; k < 5; k++) chk("e_order", log_at(k), exp_e[k]);

    // packet lock: requester 1 holds the grant for its whole packet
    begin_phase();
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33});
    rq[0].push_back({1'b1, 8'h44});
    drain("f_drain", 400);
    for (int k = 0; k < 4; k++) chk("f_order", log_at(k), exp_f[k]);

    // burst limit forces rotation every MAXB bytes
    reset_pulse();
    begin_phase();
    for (int k = 0; k < 10; k++) rq[0].push_back({1'b0, 8'(k)});
    rq[3].push_back({1'b1, 8'hC3});
    drain("g_drain", 800);
    for (int k = 0; k < 11; k++) chk("g_order", log_at(k), exp_g[k]);
    chk("g_bytes", bytes_sent, 11);

    // requester 2 goes quiet mid-packet: grant held for its byte plus TMO idle cycles
    begin_phase();
    rq[2].push_back({1'b0, 8'h2A});
    rq[0].push_back({1'b1, 8'h0B});
    drain("h_drain", 400);
    chk("h_first", log_at(0), 8'h2A);
    chk("h_second", log_at(1), 8'h0B);
    chk("h_lock_len", n_g2, 3 + ULEN + TMO);

    // randomized traffic with gaps, busy noise and stray tx_done
    reset_pulse();
    begin_phase();
    gap_en = 1; noise = 1; u_rand = 1;
    for (int i = 0; i < N; i++) begin
      gen_q[i].delete();
      got_q[i].delete();
      for (int k = 0; k < int'($urandom_range(4, 16)); k++) begin
        logic [7:0] d;
        logic       l;
        d = 8'($urandom);
        l = ($urandom_range(0, 3) == 0);
        rq[i].push_back({l, d});
        gen_q[i].push_back(d);
      end
    end
    drain("r_drain", 20000);
    for (int i = 0; i < N; i++) begin
      int bad;
      bad = 0;
      chk("r_count", got_q[i].size(), gen_q[i].size());
      for (int k = 0; k < gen_q[i].size() && k < got_q[i].size(); k++)
        if (got_q[i][k] !== gen_q[i][k]) bad++;
      chk("r_stream", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters.
- Round-robin grant with packet lock: a requester keeps the grant until it presents req_last, reaches MAX_BURST bytes, or goes quiet for LOCK_TIMEOUT cycles.
- Sits between client logic and the UART top-level's send_request/tx_data/tx_busy/tx_done interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_BURST, 16: maximum bytes per grant before forced rotation (1..255).
- LOCK_TIMEOUT, 64: idle cycles of the locked requester before the grant is released (1..65535).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; asserted at 0
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_last  input  NUM_REQ  marks the final byte of a packet
- req_ready  output  NUM_REQ  one-hot, 1-cycle accept pulse
- send_request  output  1  1-cycle pulse to the UART transmitter
- tx_data  output  8  byte to send; stable from the send_request cycle until tx_done
- tx_busy  input  1  transmitter busy
- tx_done  input  1  1-cycle pulse at the end of the stop bit
- grant_valid  output  1  a requester currently holds the grant
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester
- bytes_sent  output  16  wrapping count of completed bytes

Behaviour:
- Reset (reset==0, asynchronous): state IDLE. All outputs are 0: req_ready, send_request, tx_data, grant_valid, grant_id, bytes_sent. The rotation pointer is 0 and the burst and timeout counters are cleared. Asserting reset mid-transmission abandons the byte, and no req_ready is issued for it.
- States: IDLE, LOAD, SEND, WAIT_DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward with wrap-around.
  - Set grant_id and grant_valid=1, clear the burst count, go to LOAD. Arbitration takes 1 cycle.
- LOAD (grant held):
  - If req_valid[grant_id]=1: pulse req_ready[grant_id] for 1 cycle, capture req_data and req_last into tx_data and last_r, increment the burst count, clear the timeout counter, go to SEND.
  - If req_valid[grant_id]=0: increment the timeout counter. When it reaches LOCK_TIMEOUT, release the grant.
- SEND:
  - When tx_busy=0: pulse send_request for 1 cycle, go to WAIT_DONE.
  - When tx_busy=1: hold in SEND and do not pulse.
- WAIT_DONE:
  - On tx_done: increment bytes_sent (wraps at 0xFFFF to 0).
  - If last_r=1 or the burst count equals MAX_BURST, release the grant. Otherwise return to LOAD.
  - tx_done outside WAIT_DONE is ignored.
- Release:
  - Set grant_valid=0 and pointer = (grant_id+1) mod NUM_REQ, go to IDLE.
  - grant_id keeps its last value.
  - A new grant is possible on the following cycle, so the bubble is 1 cycle.
- Minimum latency from req_valid in IDLE to send_request is 3 cycles (IDLE -> LOAD -> SEND, with the pulse in the SEND cycle when tx_busy=0).
- Requesters that are not granted never see req_ready. Requester data must stay stable while req_valid=1.
- Simultaneous requests are resolved purely by the rotation pointer. There are no fixed priorities.
- A single requester with continuous traffic is re-granted after each release, with a 1-cycle IDLE bubble.
- A requester dropping req_valid mid-packet keeps the grant until LOCK_TIMEOUT expires.

Test Plan:
- Single byte: req_valid[2]=1, req_data=0x5A, req_last=1. Expect req_ready[2] 2 cycles later and send_request with tx_data=0x5A. After tx_done: grant_valid=0, bytes_sent=1, pointer=3.
- Round-robin: all 4 requesters hold single-byte packets (last=1) from reset. Grants go 0,1,2,3,0. Each tx_data matches its requester's byte.
- Packet lock: requester 1 sends 3 bytes (0x11,0x22,0x33 with last on 0x33) while requester 0 is valid. Requester 0 gets no req_ready until after 0x33's tx_done.
- Burst limit: MAX_BURST=4, requester 0 streams 10 bytes without last, requester 3 is valid. Grant rotates to 3 after byte 4. Requester 0 resumes later.
- Timeout: LOCK_TIMEOUT=8, requester 2 sends 1 byte (last=0) then drops valid. Grant is released exactly 8 LOAD cycles later and requester 0 is granted.
- tx_busy hold plus reset: tx_busy=1 on entry to SEND gives no send_request until it falls. Asserting reset=0 in WAIT_DONE forces all outputs to 0 immediately.
